// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-multiplier issue sequencer.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROW_REQ = 2'd1,
        ISSUE   = 2'd2,
        DRAIN   = 2'd3
    } seq_state_t;

    // Index width for a range of n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_outstanding_ctr.sv
// In-flight beat counter: up on issue, down on result return, saturating at
// both ends. A return with nothing in flight is dropped and flagged.
module mm_outstanding_ctr #(
    parameter int OUTST_MAX = 4,
    parameter int OW        = $clog2(OUTST_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic          dec,
    output logic [OW-1:0] count,
    output logic          at_max,
    output logic          underflow
);

    logic dec_eff;
    logic inc_eff;

    assign at_max    = (count == OW'(OUTST_MAX));
    assign underflow = dec & (count == '0);
    assign dec_eff   = dec & (count != '0);
    assign inc_eff   = inc & (~at_max | dec_eff);

    // Counter update; clear wins over any simultaneous increment/decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc_eff && !dec_eff) begin
            count <= count + OW'(1);
        end else if (!inc_eff && dec_eff) begin
            count <= count - OW'(1);
        end
    end

endmodule

// File: rtl/mm_issue_sequencer.sv
// Issue sequencer for the matrix multiplier: walks a rows x cols output tile,
// requests one A-row per output row, issues LANES columns per beat and waits
// for all in-flight results before pulsing done.
// Optional build macro MM_SEQ_PERF_EN enables the stall_cycles counter;
// without it stall_cycles is tied to zero.
//
// Issue handshake: issue_valid offers the beat described by issue_row,
// issue_col and issue_mask; the beat transfers in a cycle where issue_valid
// and issue_ready are both high, and those fields hold steady until then.
module mm_issue_sequencer
    import mm_pkg::*;
#(
    parameter int N_MAX     = 8,
    parameter int M_MAX     = 8,
    parameter int LANES     = 2,
    parameter int OUTST_MAX = 4,
    parameter int NW        = $clog2(N_MAX + 1),
    parameter int NIW       = clog2_min1(N_MAX),
    parameter int MW        = $clog2(M_MAX + 1),
    parameter int MIW       = clog2_min1(M_MAX),
    parameter int OW        = $clog2(OUTST_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [NW-1:0]    cfg_rows,
    input  logic [MW-1:0]    cfg_cols,
    output logic             row_req,
    input  logic             row_ack,
    input  logic             fifo_full,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [NIW-1:0]   issue_row,
    output logic [MIW-1:0]   issue_col,
    output logic [LANES-1:0] issue_mask,
    input  logic             result_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      stall_cycles
);

    // One extra bit so column + LANES cannot wrap.
    localparam int CW = MW + 1;

    seq_state_t     state;
    logic [NW-1:0]  rows_q;
    logic [MW-1:0]  cols_q;
    logic [OW-1:0]  outst;
    logic           outst_at_max;
    logic           outst_uflow;
    logic           fire;
    logic           start_ok;
    logic           cfg_bad;
    logic           last_col;
    logic           last_row;
    logic [CW-1:0]  beat_end;

    assign busy        = (state != IDLE);
    assign row_req     = (state == ROW_REQ);
    assign issue_valid = (state == ISSUE) & ~fifo_full & ~outst_at_max;
    assign fire        = issue_valid & issue_ready;
    assign start_ok    = start & ~abort & (state == IDLE);
    assign cfg_bad     = (cfg_rows == '0) | (cfg_rows > NW'(N_MAX)) |
                         (cfg_cols == '0) | (cfg_cols > MW'(M_MAX));
    assign beat_end    = CW'(issue_col) + CW'(LANES);
    assign last_col    = (beat_end >= CW'(cols_q));
    assign last_row    = (NW'(issue_row) == (rows_q - NW'(1)));

    mm_outstanding_ctr #(
        .OUTST_MAX (OUTST_MAX),
        .OW        (OW)
    ) u_outst (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort | start_ok),
        .inc       (fire),
        .dec       (result_valid),
        .count     (outst),
        .at_max    (outst_at_max),
        .underflow (outst_uflow)
    );

    // Lane i is live while its column is inside the tile; all lanes off outside ISSUE.
    always_comb begin
        issue_mask = '0;
        if (state == ISSUE) begin
            for (int i = 0; i < LANES; i++) begin
                issue_mask[i] = ((CW'(issue_col) + CW'(i)) < CW'(cols_q));
            end
        end
    end

    // Control FSM: job setup, row fetch, beat issue and result drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            issue_row <= '0;
            issue_col <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (outst_uflow) begin
                err <= 1'b1;
            end
            if (abort) begin
                state     <= IDLE;
                issue_row <= '0;
                issue_col <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rows_q    <= cfg_rows;
                            cols_q    <= cfg_cols;
                            issue_row <= '0;
                            issue_col <= '0;
                            err       <= cfg_bad | outst_uflow;
                            if (!cfg_bad) begin
                                state <= ROW_REQ;
                            end
                        end
                    end
                    ROW_REQ: begin
                        if (row_ack) begin
                            issue_col <= '0;
                            state     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (fire) begin
                            if (last_col) begin
                                if (last_row) begin
                                    state <= DRAIN;
                                end else begin
                                    issue_row <= issue_row + NIW'(1);
                                    state     <= ROW_REQ;
                                end
                            end else begin
                                issue_col <= issue_col + MIW'(LANES);
                            end
                        end
                    end
                    DRAIN: begin
                        if (outst == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MM_SEQ_PERF_EN
    // Count ISSUE cycles without a transfer; restart per job, saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if ((state == ISSUE) && !fire && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
